// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle for apb_slave_regfile.
// Pstrb exists only when APB_PSTRB_EN is defined.
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    Psel;
  logic                    Penable;
  logic                    Pwrite;
  logic [ADDR_WIDTH-1:0]   Paddr;
  logic [DATA_WIDTH-1:0]   Pwdata;
`ifdef APB_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] Pstrb;
`endif
  logic [DATA_WIDTH-1:0]   Prdata;
  logic                    Pready;
  logic                    Pslverr;

`ifdef APB_PSTRB_EN
  modport master (
    output Psel, Penable, Pwrite,
    output Paddr, Pwdata, Pstrb,
    input  Prdata, Pready, Pslverr
  );
  modport slave (
    input  Psel, Penable, Pwrite,
    input  Paddr, Pwdata, Pstrb,
    output Prdata, Pready, Pslverr
  );
`else
  modport master (
    output Psel, Penable, Pwrite,
    output Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );
  modport slave (
    input  Psel, Penable, Pwrite,
    input  Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
`endif
endinterface

// File: rtl/apb_slave_regfile.sv
// APB slave register file, programmable wait states, Pslverr.
// Define APB_PSTRB_EN for APB4 byte strobes.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic Pclk,
  input logic Presetn,
  apb_slave_regfile_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LG = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] ADEPTH =
    ADDR_WIDTH'(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  state_t state_nx;
  state_t phase;
  logic [3:0] count;
  logic [3:0] count_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         lanes;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] slot;
  logic [IW-1:0]         idx;
  logic                  range_err;
  logic                  align_err;
  logic                  strb_err;
  logic                  err;
  logic                  ready;
  logic                  write_en;

  // SETUP is the bus cycle with Psel & !Penable seen
  // outside ACCESS, so a transfer costs only 2 cycles.
  always_comb begin
    phase    = IDLE;
    state_nx = IDLE;
    count_nx = count;
    if (state == ACCESS) begin
      phase = ACCESS;
    end else if (bus.Psel && !bus.Penable) begin
      phase = SETUP;
    end
    unique case (phase)
      IDLE: state_nx = IDLE;
      SETUP: begin
        state_nx = ACCESS;
        count_nx = '0;
      end
      ACCESS: begin
        if (!bus.Psel || ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = ACCESS;
          if (count < WS) count_nx = count + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Capture the request at the end of SETUP.
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (phase == SETUP) begin
      addr_q  <= bus.Paddr;
      wr_q    <= bus.Pwrite;
      wdata_q <= bus.Pwdata;
    end
  end

`ifdef APB_PSTRB_EN
  logic [NB-1:0] strb_q;

  // Strobes are captured alongside the address.
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      strb_q <= '0;
    end else if (phase == SETUP) begin
      strb_q <= bus.Pstrb;
    end
  end

  assign lanes    = strb_q;
  assign strb_err = !wr_q && (strb_q != '0);
`else
  assign lanes    = '1;
  assign strb_err = 1'b0;
`endif

  assign offset    = addr_q - BASE_ADDR;
  assign slot      = offset >> LG;
  assign idx       = slot[IW-1:0];
  assign range_err = (addr_q < BASE_ADDR) ||
                     (slot >= ADEPTH);
  assign align_err = (offset & AMASK) != '0;
  assign err       = range_err || align_err || strb_err;

  assign ready    = (state == ACCESS) && (count == WS);
  assign write_en = bus.Psel && bus.Penable && ready &&
                    wr_q && !err;

  // Register bank with per-lane write enables.
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_en) begin
      for (int b = 0; b < NB; b++) begin
        if (lanes[b]) begin
          regs[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.Pready  = ready;
  assign bus.Pslverr = ready && err;
  assign bus.Prdata  = (ready && !wr_q && !err) ?
                       regs[idx] : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: dut0 has no wait states, base 0;
// dut1 has 3 wait states, base 0x100.
module tb_apb_slave_regfile;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn    [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic        pready  [2];

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32))
    bus0 ();
  apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32))
    bus1 ();

  assign bus0.Psel    = psel[0];
  assign bus0.Penable = penable[0];
  assign bus0.Pwrite  = pwrite[0];
  assign bus0.Paddr   = paddr[0];
  assign bus0.Pwdata  = pwdata[0];
  assign bus1.Psel    = psel[1];
  assign bus1.Penable = penable[1];
  assign bus1.Pwrite  = pwrite[1];
  assign bus1.Paddr   = paddr[1];
  assign bus1.Pwdata  = pwdata[1];
`ifdef APB_PSTRB_EN
  assign bus0.Pstrb   = pstrb[0];
  assign bus1.Pstrb   = pstrb[1];
`endif
  assign pready[0] = bus0.Pready;
  assign pready[1] = bus1.Pready;

  apb_slave_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
    .WAIT_STATES(0), .BASE_ADDR(32'h0)
  ) dut0 (
    .Pclk(clk), .Presetn(rstn[0]), .bus(bus0)
  );

  apb_slave_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
    .WAIT_STATES(3), .BASE_ADDR(32'h100)
  ) dut1 (
    .Pclk(clk), .Presetn(rstn[1]), .bus(bus1)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic mon(input int b, input logic rdy,
                     input logic [31:0] rd,
                     input logic se);
    exp_t e;
    int   n;
    if (!mon_en) return;
    if (rdy) begin
      n = (b == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready bus%0d: got 1 expected 0",
                 b);
      end else begin
        if (b == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata bus%0d", b), rd, e.rdata);
        chk($sformatf("slverr bus%0d", b), 32'(se),
            32'(e.err));
      end
    end else begin
      chk($sformatf("quiet_rdata bus%0d", b), rd, 32'h0);
      chk($sformatf("quiet_err bus%0d", b), 32'(se), 32'h0);
    end
  endtask

  always @(negedge clk)
    mon(0, bus0.Pready, bus0.Prdata, bus0.Pslverr);
  always @(negedge clk)
    mon(1, bus1.Pready, bus1.Prdata, bus1.Pslverr);

  task automatic xfer(input int b, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input logic [31:0] er,
                      input logic ee,
                      input logic scramble);
    exp_t e;
    int   cyc;
    int   ws;
    ws = (b == 0) ? 0 : 3;
    psel[b]    = 1'b1;
    penable[b] = 1'b0;
    pwrite[b]  = wr;
    paddr[b]   = a;
    pwdata[b]  = d;
    pstrb[b]   = s;
    e.rdata = er;
    e.err   = ee;
    if (b == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    penable[b] = 1'b1;
    if (scramble) begin
      paddr[b]  = a ^ 32'h0C;
      pwdata[b] = ~d;
      pwrite[b] = ~wr;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pready[b] && cyc < 40);
    chk($sformatf("latency bus%0d", b), 32'(cyc),
        32'(ws + 1));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int b, input int n);
    psel[b]    = 1'b0;
    penable[b] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rd(input int b, input logic [31:0] a,
                    input logic [31:0] er,
                    input logic ee);
    xfer(b, 1'b0, a, 32'h0, 4'h0, er, ee, 1'b0);
  endtask

  task automatic wr(input int b, input logic [31:0] a,
                    input logic [31:0] d,
                    input logic ee);
    xfer(b, 1'b1, a, d, 4'hF, 32'h0, ee, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++) begin
      rstn[b]    = 1'b0;
      psel[b]    = 1'b0;
      penable[b] = 1'b0;
      pwrite[b]  = 1'b0;
      paddr[b]   = 32'h0;
      pwdata[b]  = 32'h0;
      pstrb[b]   = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    mon_en  = 1'b1;
    idle(0, 2);

    for (int i = 0; i < 16; i++)
      rd(0, 32'(i * 4), 32'h0, 1'b0);
    rd(1, 32'h100, 32'h0, 1'b0);
    rd(1, 32'h13C, 32'h0, 1'b0);

    wr(0, 32'h08, 32'hDEADBEEF, 1'b0);
    rd(0, 32'h08, 32'hDEADBEEF, 1'b0);
    wr(0, 32'h3C, 32'hCAFEF00D, 1'b0);
    rd(0, 32'h3C, 32'hCAFEF00D, 1'b0);
    xfer(0, 1'b1, 32'h14, 32'h600DF00D, 4'hF,
         32'h0, 1'b0, 1'b1);
    rd(0, 32'h14, 32'h600DF00D, 1'b0);
    rd(0, 32'h18, 32'h0, 1'b0);

    wr(0, 32'h40, 32'hFFFFFFFF, 1'b1);
    rd(0, 32'h40, 32'h0, 1'b1);
    wr(0, 32'h02, 32'hFFFFFFFF, 1'b1);
    rd(0, 32'h0A, 32'h0, 1'b1);
    rd(0, 32'h00, 32'h0, 1'b0);
    rd(0, 32'h08, 32'hDEADBEEF, 1'b0);
    rd(0, 32'h3C, 32'hCAFEF00D, 1'b0);

`ifdef APB_PSTRB_EN
    wr(0, 32'h10, 32'h11223344, 1'b0);
    xfer(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101,
         32'h0, 1'b0, 1'b0);
    rd(0, 32'h10, 32'h11BB33DD, 1'b0);
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000,
         32'h0, 1'b0, 1'b0);
    rd(0, 32'h10, 32'h11BB33DD, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'b0001,
         32'h0, 1'b1, 1'b0);
`endif
    idle(0, 1);

    xfer(1, 1'b1, 32'h104, 32'h000055AA, 4'hF,
         32'h0, 1'b0, 1'b1);
    rd(1, 32'h104, 32'h000055AA, 1'b0);
    rd(1, 32'h108, 32'h0, 1'b0);
    rd(1, 32'h0FC, 32'h0, 1'b1);
    wr(1, 32'h140, 32'hFFFFFFFF, 1'b1);
    wr(1, 32'h102, 32'hFFFFFFFF, 1'b1);
    rd(1, 32'h100, 32'h0, 1'b0);
    rd(1, 32'h104, 32'h000055AA, 1'b0);
    idle(1, 1);

    psel[1]    = 1'b1;
    penable[1] = 1'b0;
    pwrite[1]  = 1'b1;
    paddr[1]   = 32'h104;
    pwdata[1]  = 32'h1234;
    pstrb[1]   = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    idle(1, 2);
    psel[1]    = 1'b1;
    penable[1] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    idle(1, 1);
    rd(1, 32'h104, 32'h000055AA, 1'b0);

    psel[1]    = 1'b1;
    penable[1] = 1'b0;
    pwrite[1]  = 1'b1;
    paddr[1]   = 32'h104;
    pwdata[1]  = 32'h1234;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    idle(1, 3);
    rd(1, 32'h104, 32'h0, 1'b0);
    wr(1, 32'h13C, 32'h0BADCAFE, 1'b0);
    rd(1, 32'h13C, 32'h0BADCAFE, 1'b0);
    idle(1, 4);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
